// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the multicycle fetch unit: opcode constants,
// the next-PC source select encoding and the default reset PC.
package fetch_unit_pkg;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'b00,
        PCSRC_JUMP   = 2'b01,
        PCSRC_BRANCH = 2'b10,
        PCSRC_REG    = 2'b11
    } pcsrc_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Controller strobes and unified-memory bus between the multicycle
// controller/memory (master) and the fetch unit (slave).
interface fetch_unit_if;

    logic        PCWrite;
    logic        PCWriteCond;
    logic        IRWrite;
    logic        IorD;
    logic [1:0]  PCSrc;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    modport master (
        output PCWrite, PCWriteCond, IRWrite, IorD, PCSrc, mem_rdata,
        input  mem_addr
    );

    modport slave (
        input  PCWrite, PCWriteCond, IRWrite, IorD, PCSrc, mem_rdata,
        output mem_addr
    );

endinterface

// File: rtl/fetch_unit_npc_select.sv
// Combinational next-PC selection: evaluates the branch condition from the
// IR opcode, chooses the PC source, forces word alignment and reports
// whether a load would use a misaligned source.
module npc_select
    import fetch_unit_pkg::*;
(
    input  logic        pcwrite,
    input  logic        pcwritecond,
    input  logic        zeroflag,
    input  logic [1:0]  pcsrc,
    input  logic [3:0]  pc_hi,
    input  logic [31:0] instruction,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] reg_a,
    output logic        pc_load,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] src;
    logic        branch_cond;

    // Branch condition from the opcode, source mux, and load/misalign decode
    always_comb begin
        branch_cond = 1'b0;
        case (instruction[31:26])
            OP_BEQ:  branch_cond = zeroflag;
            OP_BNE:  branch_cond = !zeroflag;
            default: branch_cond = 1'b0;
        endcase

        src = alu_result;
        case (pcsrc_e'(pcsrc))
            PCSRC_SEQ:    src = alu_result;
            PCSRC_JUMP:   src = {pc_hi, instruction[25:0], 2'b00};
            PCSRC_BRANCH: src = alu_out;
            PCSRC_REG:    src = reg_a;
            default:      src = alu_result;
        endcase

        pc_load    = pcwrite | (pcwritecond & branch_cond);
        next_pc    = {src[31:2], 2'b00};
        misaligned = pc_load & (src[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Multicycle fetch unit: holds PC, IR and MDR, drives the unified memory
// address and flags misaligned PC targets (sticky until reset).
// Optional feature macro: FETCH_PERF_CNT_EN adds instr_count/cycle_count.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.slave bus,
    input  logic        zeroflag,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] reg_a,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic [31:0] mdr,
    output logic        pc_misaligned
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
`endif
);

    logic        pc_load;
    logic [31:0] next_pc;
    logic        misaligned;

    npc_select u_npc_select (
        .pcwrite     (bus.PCWrite),
        .pcwritecond (bus.PCWriteCond),
        .zeroflag    (zeroflag),
        .pcsrc       (bus.PCSrc),
        .pc_hi       (pc[31:28]),
        .instruction (instruction),
        .alu_result  (alu_result),
        .alu_out     (alu_out),
        .reg_a       (reg_a),
        .pc_load     (pc_load),
        .next_pc     (next_pc),
        .misaligned  (misaligned)
    );

    assign bus.mem_addr = bus.IorD ? alu_out : pc;

    // PC update and sticky misalignment flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            pc_misaligned <= 1'b0;
        end else begin
            if (pc_load) begin
                pc <= next_pc;
            end
            if (misaligned) begin
                pc_misaligned <= 1'b1;
            end
        end
    end

    // IR captures memory data on IRWrite; MDR captures it every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction <= 32'h0;
            mdr         <= 32'h0;
        end else begin
            if (bus.IRWrite) begin
                instruction <= bus.mem_rdata;
            end
            mdr <= bus.mem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: fetched instructions and cycles out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= 32'h0;
            cycle_count <= 32'h0;
        end else begin
            if (bus.IRWrite) begin
                instr_count <= instr_count + 32'd1;
            end
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// stimulus compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic        zeroflag;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [31:0] reg_a;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] mdr;
    logic        pc_misaligned;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instr_count;
    logic [31:0] cycle_count;
`endif

    fetch_unit_if u_if ();

    fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (u_if.slave),
        .zeroflag      (zeroflag),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .reg_a         (reg_a),
        .pc            (pc),
        .instruction   (instruction),
        .mdr           (mdr),
        .pc_misaligned (pc_misaligned)
`ifdef FETCH_PERF_CNT_EN
        ,
        .instr_count   (instr_count),
        .cycle_count   (cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVectors = 0;
    int nMiscompares = 0;

    // Behavioural model state
    logic [31:0] mPc;
    logic [31:0] mIr;
    logic [31:0] mMdr;
    logic        mMis;
    logic [31:0] mInstr;
    logic [31:0] mCyc;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, actual, expected);
        end
    endtask

    task automatic clearInputs();
        u_if.PCWrite     = 1'b0;
        u_if.PCWriteCond = 1'b0;
        u_if.IRWrite     = 1'b0;
        u_if.IorD        = 1'b0;
        u_if.PCSrc       = 2'b00;
        u_if.mem_rdata   = 32'h0;
        zeroflag         = 1'b0;
        alu_result       = 32'h0;
        alu_out          = 32'h0;
        reg_a            = 32'h0;
    endtask

    task automatic modelReset();
        mPc    = TB_RESET_PC;
        mIr    = 32'h0;
        mMdr   = 32'h0;
        mMis   = 1'b0;
        mInstr = 32'h0;
        mCyc   = 32'h0;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".pc"}, pc, mPc);
        checkOutput({tag, ".ir"}, instruction, mIr);
        checkOutput({tag, ".mdr"}, mdr, mMdr);
        checkOutput({tag, ".mis"}, {31'h0, pc_misaligned}, {31'h0, mMis});
`ifdef FETCH_PERF_CNT_EN
        checkOutput({tag, ".icnt"}, instr_count, mInstr);
        checkOutput({tag, ".ccnt"}, cycle_count, mCyc);
`endif
    endtask

    task automatic doReset(input string tag);
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        modelReset();
        checkState(tag);
        rst = 1'b0;
    endtask

    // One clock of operation: predict from the fetch rules, clock, compare
    task automatic applyStimulus(input string tag);
        logic [31:0] src;
        logic        cond;
        logic        taken;
        logic [5:0]  op;
        #1;
        checkOutput({tag, ".addr"}, u_if.mem_addr, u_if.IorD ? alu_out : mPc);
        op   = mIr[31:26];
        cond = (op == 6'd4) ? zeroflag : (op == 6'd5) ? !zeroflag : 1'b0;
        taken = u_if.PCWrite || (u_if.PCWriteCond && cond);
        case (u_if.PCSrc)
            2'd0:    src = alu_result;
            2'd1:    src = (mPc & 32'hF000_0000) | ((mIr & 32'h03FF_FFFF) * 4);
            2'd2:    src = alu_out;
            default: src = reg_a;
        endcase
        if (taken) begin
            mPc = src - (src % 4);
            if (src % 4 != 0) mMis = 1'b1;
        end
        if (u_if.IRWrite) begin
            mIr    = u_if.mem_rdata;
            mInstr = mInstr + 1;
        end
        mMdr = u_if.mem_rdata;
        mCyc = mCyc + 1;
        @(posedge clk);
        #1;
        checkState(tag);
    endtask

    task automatic randomInputs();
        logic [31:0] r;
        logic [5:0]  op;
        int          sel;
        r   = $urandom();
        sel = $urandom_range(0, 3);
        op  = (sel == 0) ? 6'd4 : (sel == 1) ? 6'd5 : (sel == 2) ? 6'd2 : r[31:26];
        u_if.mem_rdata   = {op, r[25:0]};
        u_if.PCWrite     = ($urandom_range(0, 3) == 0);
        u_if.PCWriteCond = ($urandom_range(0, 1) == 0);
        u_if.IRWrite     = ($urandom_range(0, 2) == 0);
        u_if.IorD        = ($urandom_range(0, 1) == 0);
        u_if.PCSrc       = 2'($urandom_range(0, 3));
        zeroflag         = ($urandom_range(0, 1) == 0);
        r = $urandom();
        alu_result = ($urandom_range(0, 7) == 0) ? r : (r & 32'hFFFF_FFFC);
        r = $urandom();
        alu_out    = ($urandom_range(0, 7) == 0) ? r : (r & 32'hFFFF_FFFC);
        r = $urandom();
        reg_a      = ($urandom_range(0, 7) == 0) ? r : (r & 32'hFFFF_FFFC);
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();
        modelReset();

        doReset("reset");
        checkOutput("reset.pc_const", pc, TB_RESET_PC);

        // First fetch: sequential PC and IR capture
        u_if.IRWrite = 1'b1; u_if.PCWrite = 1'b1; u_if.PCSrc = 2'b00;
        alu_result = 32'h4; u_if.mem_rdata = 32'h2008_0005;
        applyStimulus("fetch1");
        checkOutput("fetch1.pc_const", pc, 32'h4);
        checkOutput("fetch1.ir_const", instruction, 32'h2008_0005);

        // beq taken / not taken
        clearInputs(); u_if.IRWrite = 1'b1; u_if.mem_rdata = 32'h1000_0003;
        applyStimulus("ld_beq");
        clearInputs(); u_if.PCWriteCond = 1'b1; u_if.PCSrc = 2'b10; alu_out = 32'h20; zeroflag = 1'b1;
        applyStimulus("beq_t");
        checkOutput("beq_t.pc_const", pc, 32'h20);
        alu_out = 32'h60; zeroflag = 1'b0;
        applyStimulus("beq_nt");
        checkOutput("beq_nt.pc_const", pc, 32'h20);

        // bne taken / not taken
        clearInputs(); u_if.IRWrite = 1'b1; u_if.mem_rdata = 32'h1400_0003;
        applyStimulus("ld_bne");
        clearInputs(); u_if.PCWriteCond = 1'b1; u_if.PCSrc = 2'b10; alu_out = 32'h40; zeroflag = 1'b0;
        applyStimulus("bne_t");
        checkOutput("bne_t.pc_const", pc, 32'h40);
        alu_out = 32'h80; zeroflag = 1'b1;
        applyStimulus("bne_nt");
        checkOutput("bne_nt.pc_const", pc, 32'h40);

        // Jump: PC and IR load on the same edge, then jump
        clearInputs(); u_if.PCWrite = 1'b1; alu_result = 32'h1000_0000;
        u_if.IRWrite = 1'b1; u_if.mem_rdata = 32'h0800_0010;
        applyStimulus("pre_j");
        clearInputs(); u_if.PCWrite = 1'b1; u_if.PCSrc = 2'b01;
        applyStimulus("jump");
        checkOutput("jump.pc_const", pc, 32'h1000_0040);

        // Wrap through alu_result
        clearInputs(); u_if.PCWrite = 1'b1; alu_result = 32'hFFFF_FFFC;
        applyStimulus("pre_wrap");
        alu_result = 32'h0;
        applyStimulus("wrap");

        // jr to a misaligned target: sticky flag
        clearInputs(); u_if.PCWrite = 1'b1; u_if.PCSrc = 2'b11; reg_a = 32'h0000_0102;
        applyStimulus("jr_mis");
        checkOutput("jr_mis.pc_const", pc, 32'h100);
        checkOutput("jr_mis.flag_const", {31'h0, pc_misaligned}, 32'h1);
        clearInputs();
        for (int i = 0; i < 10; i++) applyStimulus("idle");
        checkOutput("sticky.flag_const", {31'h0, pc_misaligned}, 32'h1);

        // Data address path
        u_if.IorD = 1'b1; alu_out = 32'h80;
        #1;
        checkOutput("iord.addr_const", u_if.mem_addr, 32'h80);

        // Mid-cycle reset with a load pending
        clearInputs(); u_if.PCWrite = 1'b1; alu_result = 32'h0000_1234;
        applyStimulus("pre_rst");
        alu_result = 32'h0000_5678;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst.pc", pc, TB_RESET_PC);
        checkOutput("midrst.ir", instruction, 32'h0);
        checkOutput("midrst.mis", {31'h0, pc_misaligned}, 32'h0);
        u_if.PCWrite = 1'b0;
        checkOutput("midrst.addr", u_if.mem_addr, TB_RESET_PC);
        @(negedge clk);
        modelReset();
        rst = 1'b0;
        checkState("post_rst");

        // Three fetches after reset
        for (int i = 0; i < 3; i++) begin
            clearInputs(); u_if.IRWrite = 1'b1; u_if.PCWrite = 1'b1;
            alu_result = mPc + 32'd4; u_if.mem_rdata = $urandom();
            applyStimulus("fetch3");
        end
`ifdef FETCH_PERF_CNT_EN
        checkOutput("fetch3.icnt_const", instr_count, 32'd3);
`endif

        // Randomized operation with occasional resets
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) doReset("rand_rst");
            randomInputs();
            applyStimulus("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
